// File: rtl/ysyx_23060077_lsu_sram_pkg.sv
// Shared widths, size encodings and the default SRAM base address for the
// LSU SRAM responder and its lane helper.
package ysyx_23060077_lsu_sram_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_SIZE_WIDTH = 3;
    localparam int AXI_LEN_WIDTH  = 8;

    localparam logic [AXI_ADDR_WIDTH-1:0] LSU_SRAM_BASE_ADDR = 32'h8000_0000;

    localparam logic [AXI_SIZE_WIDTH-1:0] SIZE_B = 3'd0;
    localparam logic [AXI_SIZE_WIDTH-1:0] SIZE_H = 3'd1;
    localparam logic [AXI_SIZE_WIDTH-1:0] SIZE_W = 3'd2;

endpackage

// File: rtl/ysyx_23060077_lsu_lane.sv
// Byte-lane helper: size/lane to write mask, write data shift-up, read data
// shift-down and natural-alignment check. Purely combinational.
module ysyx_23060077_lsu_lane
    import ysyx_23060077_lsu_sram_pkg::*;
(
    input  logic [AXI_SIZE_WIDTH-1:0] size,
    input  logic [1:0]                lane,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH-1:0]     rword,
    output logic [3:0]                wmask,
    output logic [DATA_WIDTH-1:0]     wdata_shift,
    output logic [DATA_WIDTH-1:0]     rdata_shift,
    output logic                      misaligned
);

    logic [3:0] base_mask_s;

    // Unshifted mask and alignment fault per access size; unknown sizes always fault.
    always_comb begin
        base_mask_s = 4'b0000;
        misaligned  = 1'b0;
        case (size)
            SIZE_B: begin
                base_mask_s = 4'b0001;
                misaligned  = 1'b0;
            end
            SIZE_H: begin
                base_mask_s = 4'b0011;
                misaligned  = lane[0];
            end
            SIZE_W: begin
                base_mask_s = 4'b1111;
                misaligned  = (lane != 2'b00);
            end
            default: begin
                base_mask_s = 4'b0000;
                misaligned  = 1'b1;
            end
        endcase
    end

    assign wmask       = base_mask_s << lane;
    assign wdata_shift = wdata << {lane, 3'b000};
    assign rdata_shift = rword >> {lane, 3'b000};

endmodule

// File: rtl/ysyx_23060077_lsu_sram.sv
// LSU request responder backed by a word-organised SRAM model, with a
// fixed response latency and alignment/range/len fault reporting.
module ysyx_23060077_lsu_sram
    import ysyx_23060077_lsu_sram_pkg::*;
#(
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR   = LSU_SRAM_BASE_ADDR,
    parameter int                        DEPTH_WORDS = 1024,
    parameter int                        LATENCY     = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      lsu_r_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] lsu_r_addr_i,
    input  logic [AXI_SIZE_WIDTH-1:0] lsu_r_size_i,
    input  logic [AXI_LEN_WIDTH-1:0]  lsu_r_len_i,
    output logic                      lsu_r_ready_o,
    output logic [DATA_WIDTH-1:0]     lsu_r_data_o,
    output logic                      lsu_r_last_o,
    input  logic                      lsu_w_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] lsu_w_addr_i,
    input  logic [DATA_WIDTH-1:0]     lsu_w_data_i,
    input  logic [AXI_SIZE_WIDTH-1:0] lsu_w_size_i,
    input  logic [AXI_LEN_WIDTH-1:0]  lsu_w_len_i,
    output logic                      lsu_w_ready_o,
    output logic                      lsu_w_last_o,
    output logic                      resp_err_o
);

    localparam int                        IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_BYTES = AXI_ADDR_WIDTH'(DEPTH_WORDS * 4);
    localparam logic [7:0]                LAT_C       = 8'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                    state_r, state_nxt_s;
    logic [7:0]                cnt_r, cnt_nxt_s;
    logic                      accept_s, accept_wr_s, done_s;
    logic                      dir_r;
    logic [AXI_ADDR_WIDTH-1:0] addr_r;
    logic [AXI_SIZE_WIDTH-1:0] size_r;
    logic [AXI_LEN_WIDTH-1:0]  len_r;
    logic [DATA_WIDTH-1:0]     wdata_r;

    logic [AXI_ADDR_WIDTH-1:0] off_s;
    logic [IDX_W-1:0]          index_s;
    logic                      in_range_s, misaligned_s, fault_s, commit_s;
    logic [3:0]                wmask_s;
    logic [DATA_WIDTH-1:0]     wdata_shift_s, rdata_shift_s;
    logic [DATA_WIDTH-1:0]     mem_r [DEPTH_WORDS];

    logic                      r_ready_r, r_last_r, w_ready_r, w_last_r, err_r;
    logic [DATA_WIDTH-1:0]     r_data_r;

    // Unsigned wrap-around compare makes addresses below BASE_ADDR out of range too.
    assign off_s      = addr_r - BASE_ADDR;
    assign index_s    = off_s[IDX_W+1:2];
    assign in_range_s = (off_s < DEPTH_BYTES);
    assign fault_s    = misaligned_s | (len_r != '0) | ~in_range_s;
    assign commit_s   = done_s & dir_r & ~fault_s & reset;

    ysyx_23060077_lsu_lane u_lane (
        .size        (size_r),
        .lane        (addr_r[1:0]),
        .wdata       (wdata_r),
        .rword       (mem_r[index_s]),
        .wmask       (wmask_s),
        .wdata_shift (wdata_shift_s),
        .rdata_shift (rdata_shift_s),
        .misaligned  (misaligned_s)
    );

    // FSM state and latency counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; a simultaneous read and write request is resolved in favour of the read.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        accept_wr_s = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (lsu_r_valid_i) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = LAT_C;
                end else if (lsu_w_valid_i) begin
                    accept_s    = 1'b1;
                    accept_wr_s = 1'b1;
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = LAT_C;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 8'd0) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request capture on accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_r   <= 1'b0;
            addr_r  <= '0;
            size_r  <= '0;
            len_r   <= '0;
            wdata_r <= '0;
        end else if (accept_s) begin
            if (accept_wr_s) begin
                dir_r   <= 1'b1;
                addr_r  <= lsu_w_addr_i;
                size_r  <= lsu_w_size_i;
                len_r   <= lsu_w_len_i;
                wdata_r <= lsu_w_data_i;
            end else begin
                dir_r   <= 1'b0;
                addr_r  <= lsu_r_addr_i;
                size_r  <= lsu_r_size_i;
                len_r   <= lsu_r_len_i;
                wdata_r <= '0;
            end
        end
    end

    // Response pulses; read data is held until the next read response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready_r <= 1'b0;
            r_last_r  <= 1'b0;
            w_ready_r <= 1'b0;
            w_last_r  <= 1'b0;
            err_r     <= 1'b0;
            r_data_r  <= '0;
        end else begin
            r_ready_r <= done_s & ~dir_r;
            r_last_r  <= done_s & ~dir_r;
            w_ready_r <= accept_s & accept_wr_s;
            w_last_r  <= done_s & dir_r;
            err_r     <= done_s & fault_s;
            if (done_s && !dir_r) begin
                r_data_r <= fault_s ? '0 : rdata_shift_s;
            end
        end
    end

    // Byte-wise SRAM commit on the WAIT->RESP edge; contents survive reset.
    always_ff @(posedge clock) begin
        if (commit_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) begin
                    mem_r[index_s][8*b +: 8] <= wdata_shift_s[8*b +: 8];
                end
            end
        end
    end

    assign lsu_r_ready_o = r_ready_r;
    assign lsu_r_last_o  = r_last_r;
    assign lsu_r_data_o  = r_data_r;
    assign lsu_w_ready_o = w_ready_r;
    assign lsu_w_last_o  = w_last_r;
    assign resp_err_o    = err_r;

endmodule
